regfile: RTL and testbench
==========================

# regfile

Parametrised general-purpose register file for the multi-cycle CPU datapath. It holds 2**ADDR_W words of WIDTH bits and provides one synchronous write port and two registered read ports, each with its own read enable. Each read-port output keeps its value until that port's enable is asserted again, so it can serve directly as the A/B operand latches between the decode and execute states. Entry 0 can be hardwired to zero.

## Interface
- WIDTH, 32, data word width in bits (≥1)
- ADDR_W, 5, address width; the file holds 2**ADDR_W entries (≥1)
- ZERO_R0, 1, when 1: entry 0 always reads 0 and ignores writes
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; **synchronous, active-low**
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  WIDTH  write data
- re_a  in  1  read enable, port A
- raddr_a  in  ADDR_W  read address, port A
- rdata_a  out  WIDTH  registered read data, port A
- re_b  in  1  read enable, port B
- raddr_b  in  ADDR_W  read address, port B
- rdata_b  out  WIDTH  registered read data, port B

## Operation
- **Reset.** When rst is 0 at a rising edge:
  - every entry clears to 0;
  - rdata_a and rdata_b clear to 0;
  - we, re_a and re_b are ignored that cycle.
- **Write.** When we=1 at an edge, entry[waddr] takes wdata.
  - Exception: the write is dropped when ZERO_R0=1 and waddr=0.
- **Read, each port independently.**
  - When re_x=1 at an edge, rdata_x takes the value of entry[raddr_x].
  - When re_x=0, rdata_x holds its previous value indefinitely.
  - If ZERO_R0=1 and raddr_x=0, the loaded value is 0.
- **Read/write collision.** re_x=1, we=1 and raddr_x=waddr in the same cycle:
  - With the bypass macro defined: rdata_x loads the new wdata.
  - Without it: rdata_x loads the old entry contents.
  - An address of 0 with ZERO_R0=1 loads 0 in both cases.
- **Both ports, same address.** Allowed; both ports load identical data.
- **Bit-width.** No width conversion anywhere. Addresses are used in full, so every address value is valid and no out-of-range case exists.

## Timing
- Write latency is 1 edge: data written at edge N is present in the array after edge N.
- Read latency is 1 edge: rdata_x is valid after the edge at which re_x=1 was sampled.
- Write followed by read of the same address:
  - Write at edge N and read at edge N+1 always returns the new data, with or without the bypass.
  - Same-edge read and write follows the collision rule above.
- Reset takes effect at the first edge where rst=0. Normal operation resumes at the first edge where rst=1.
- Reset asserted mid-sequence: any write or read enable presented in that cycle is lost. All outputs are 0 from the following cycle.
- There are no combinational paths from any input to rdata_a or rdata_b.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- **Defined:** adds write-to-read forwarding on both ports for same-edge address matches, so the port loads wdata.
- **Undefined:** no forwarding logic is built; a same-edge read returns the pre-write contents.
- Reset, write and ZERO_R0 behaviour are identical in both builds.

## Structure
- Shared package regfile_pkg holds:
  - default constants RF_WIDTH=32, RF_ADDR_W=5;
  - the constant RF_ZERO_ADDR=0;
  - a typedef for the data word (rf_word_t).
- One sub-module, regfile_entry. It is a single WIDTH-bit storage word with:
  - a write-enable input;
  - synchronous active-low clear;
  - one instance per address, generated.
- The top level holds:
  - write-address decode;
  - two read muxes;
  - optional bypass compare;
  - the two output registers.

## Test plan
- **Reset clears everything.** Load entries 1..31 with non-zero values, then hold rst=0 for one edge and read addresses 1 and 31 on ports A/B. Required: rdata_a=0 and rdata_b=0, and the outputs are 0 immediately after the reset edge.
- **Basic write/read.** Write 0xDEADBEEF to address 5, then the next cycle re_a=1 with raddr_a=5. Required: rdata_a=0xDEADBEEF one edge later, and rdata_b unchanged.
- **Zero register.** With ZERO_R0=1, write 0xFFFFFFFF to address 0, then read address 0 on both ports. Required: both ports read 0. With ZERO_R0=0, both ports read 0xFFFFFFFF.
- **Hold.** Read address 7 (0x12345678) on port A, overwrite address 7 with 0x0, and keep re_a=0 for 3 cycles. Required: rdata_a stays 0x12345678.
- **Collision.** Address 9 holds 0x11. In the same cycle, write 0x22 to address 9 and read address 9 on both ports. Required: both ports read 0x22 with REGFILE_BYPASS_EN defined, and 0x11 without it.
- **Reset versus enables.** Assert rst=0 in the same cycle as we=1 (address 3, data 0x55) and re_b=1. Required: after release, address 3 reads 0 and rdata_b=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the register file.
//   RF_WIDTH     default data word width
//   RF_ADDR_W    default address width (2**RF_ADDR_W entries)
//   RF_ZERO_ADDR address of the optional hardwired-zero entry
//   rf_word_t    data word at the default width
package regfile_pkg;

  localparam int RF_WIDTH     = 32;
  localparam int RF_ADDR_W    = 5;
  localparam int RF_ZERO_ADDR = 0;

  typedef logic [RF_WIDTH-1:0] rf_word_t;

endpackage

// File: rtl/regfile_entry.sv
// regfile_entry: one WIDTH-bit storage word of the register file.
//   clk    clock, rising edge
//   rst    synchronous active-low clear
//   we     write enable for this word (already address-decoded)
//   wdata  data to store
//   q      stored word
module regfile_entry
  import regfile_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] q
);

  // NOTE: every word has its own clear because the file must read all-zero
  // after reset; a plain RAM macro without reset could not be used here.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all clocked state, so every word
    // sees pre-edge values regardless of block evaluation order.
    if (!rst) begin
      q <= '0;
    end else if (we) begin
      q <= wdata;
    end
  end

endmodule

// File: rtl/regfile.sv
// regfile: 2**ADDR_W x WIDTH register file, one synchronous write port and
// two registered read ports (A/B) whose outputs hold until re_x is asserted
// again, so they double as the operand latches of the datapath.
//   clk               clock, rising edge
//   rst               synchronous active-low reset (clears array and outputs)
//   we/waddr/wdata    write port
//   re_a/raddr_a      read port A enable/address, rdata_a registered data
//   re_b/raddr_b      read port B enable/address, rdata_b registered data
// Parameters: WIDTH, ADDR_W, ZERO_R0 (entry 0 reads 0 and ignores writes).
// Build option: define REGFILE_BYPASS_EN to forward wdata to a read port
// whose address matches waddr on the same edge; otherwise that read returns
// the pre-write contents.
module regfile
  import regfile_pkg::*;
#(
  parameter int WIDTH   = RF_WIDTH,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_ADDR);

  logic [WIDTH-1:0] words [DEPTH];
  logic [WIDTH-1:0] next_a;
  logic [WIDTH-1:0] next_b;

  // Storage: one word per address with its write enable decoded here. The
  // zero entry, when enabled, has no storage at all, so writes to it vanish.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    if (ZERO_R0 && (i == RF_ZERO_ADDR)) begin : g_zero
      assign words[i] = '0;
    end else begin : g_store
      regfile_entry #(
        .WIDTH (WIDTH)
      ) u_entry (
        .clk   (clk),
        .rst   (rst),
        .we    (we && (waddr == ADDR_W'(i))),
        .wdata (wdata),
        .q     (words[i])
      );
    end
  end

  // Read muxes, optional same-edge forwarding, then the zero override last
  // so that forwarding can never leak a value into the zero entry.
  always_comb begin
    // NOTE: defaults first so every path assigns next_a/next_b and no latch
    // is inferred.
    next_a = words[raddr_a];
    next_b = words[raddr_b];
`ifdef REGFILE_BYPASS_EN
    if (we && (waddr == raddr_a)) next_a = wdata;
    if (we && (waddr == raddr_b)) next_b = wdata;
`endif
    if (ZERO_R0 && (raddr_a == ZERO_ADDR)) next_a = '0;
    if (ZERO_R0 && (raddr_b == ZERO_ADDR)) next_b = '0;
  end

  // Output registers: load only on their own enable, hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (re_a) rdata_a <= next_a;
      if (re_b) rdata_b <= next_b;
    end
  end

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: self-checking bench for regfile. Two instances share all
// inputs: dut (ZERO_R0=1) and dut_nz (ZERO_R0=0). A directed vector table
// covers the listed scenarios, a hand sequence covers reset of a full file,
// and randomized cycles are compared with an array-based reference model.
module tb_regfile;
  import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  localparam rf_word_t COLL = BYPASS ? 32'h22 : 32'h11;

  logic       clk = 1'b0;
  logic       rst, we, re_a, re_b;
  logic [4:0] waddr, raddr_a, raddr_b;
  rf_word_t   wdata;
  rf_word_t   rdata_a, rdata_b, rdata_nz_a, rdata_nz_b;

  int checks = 0;
  int errors = 0;

  // Reference model state
  rf_word_t mem    [32];
  rf_word_t mem_nz [32];
  rf_word_t mdl_a, mdl_b, mdl_nz_a, mdl_nz_b;

  always #5 clk = ~clk;

  regfile #(.WIDTH(32), .ADDR_W(5), .ZERO_R0(1'b1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b)
  );

  regfile #(.WIDTH(32), .ADDR_W(5), .ZERO_R0(1'b0)) dut_nz (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_nz_a),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_nz_b)
  );

  task automatic check(input string name, input rf_word_t act, input rf_word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Value a read port loads, from the behavioural rules: zero entry first,
  // then same-edge forwarding if built, else the stored word.
  function automatic rf_word_t mread(input bit zero_r0, input logic [4:0] a,
                                     input logic w, input logic [4:0] wa,
                                     input rf_word_t wd);
    if (zero_r0 && a == 5'd0) return '0;
    if (BYPASS && w && wa == a) return wd;
    return zero_r0 ? mem[a] : mem_nz[a];
  endfunction

  // One clock: drive, update the model, sample #1 after the edge, compare.
  task automatic step(input logic r, input logic w, input logic [4:0] wa,
                      input rf_word_t wd, input logic ea, input logic [4:0] ra,
                      input logic eb, input logic [4:0] rb);
    rst = r; we = w; waddr = wa; wdata = wd;
    re_a = ea; raddr_a = ra; re_b = eb; raddr_b = rb;
    if (!r) begin
      for (int i = 0; i < 32; i++) begin
        mem[i] = '0;
        mem_nz[i] = '0;
      end
      mdl_a = '0; mdl_b = '0; mdl_nz_a = '0; mdl_nz_b = '0;
    end else begin
      if (ea) begin
        mdl_a    = mread(1'b1, ra, w, wa, wd);
        mdl_nz_a = mread(1'b0, ra, w, wa, wd);
      end
      if (eb) begin
        mdl_b    = mread(1'b1, rb, w, wa, wd);
        mdl_nz_b = mread(1'b0, rb, w, wa, wd);
      end
      if (w) begin
        if (wa != 5'd0) mem[wa] = wd;
        mem_nz[wa] = wd;
      end
    end
    @(posedge clk);
    #1;
    check("model_a", rdata_a, mdl_a);
    check("model_b", rdata_b, mdl_b);
    check("model_nz_a", rdata_nz_a, mdl_nz_a);
    check("model_nz_b", rdata_nz_b, mdl_nz_b);
  endtask

  typedef struct {
    logic       rst;
    logic       we;
    logic [4:0] waddr;
    rf_word_t   wdata;
    logic       re_a;
    logic [4:0] raddr_a;
    logic       re_b;
    logic [4:0] raddr_b;
    rf_word_t   exp_a;
    rf_word_t   exp_b;
    rf_word_t   exp_nz_a;
    rf_word_t   exp_nz_b;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // rst we wa wdata        rea ra  reb rb  | a b nz_a nz_b (after the edge)
    vecs[0]  = '{0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 0, 0, 0,            1, 5, 0, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0};
    vecs[3]  = '{1, 1, 7, 32'h12345678, 0, 0, 0, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0};
    vecs[4]  = '{1, 0, 0, 0,            1, 7, 0, 0, 32'h12345678, 0, 32'h12345678, 0};
    vecs[5]  = '{1, 1, 7, 0,            0, 0, 0, 0, 32'h12345678, 0, 32'h12345678, 0};
    vecs[6]  = '{1, 0, 0, 0,            0, 7, 0, 0, 32'h12345678, 0, 32'h12345678, 0};
    vecs[7]  = '{1, 0, 0, 0,            0, 7, 0, 0, 32'h12345678, 0, 32'h12345678, 0};
    vecs[8]  = '{1, 0, 0, 0,            0, 7, 0, 0, 32'h12345678, 0, 32'h12345678, 0};
    vecs[9]  = '{1, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 32'h12345678, 0, 32'h12345678, 0};
    vecs[10] = '{1, 0, 0, 0,            1, 0, 1, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[11] = '{1, 1, 9, 32'h11,       0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[12] = '{1, 1, 9, 32'h22,       1, 9, 1, 9, COLL, COLL, COLL, COLL};
    vecs[13] = '{1, 0, 0, 0,            1, 9, 1, 9, 32'h22, 32'h22, 32'h22, 32'h22};
    vecs[14] = '{0, 1, 3, 32'h55,       0, 0, 1, 3, 0, 0, 0, 0};
    vecs[15] = '{1, 0, 0, 0,            1, 3, 1, 3, 0, 0, 0, 0};

    for (int v = 0; v < 16; v++) begin
      step(vecs[v].rst, vecs[v].we, vecs[v].waddr, vecs[v].wdata,
           vecs[v].re_a, vecs[v].raddr_a, vecs[v].re_b, vecs[v].raddr_b);
      check($sformatf("vec%0d_a", v), rdata_a, vecs[v].exp_a);
      check($sformatf("vec%0d_b", v), rdata_b, vecs[v].exp_b);
      check($sformatf("vec%0d_nz_a", v), rdata_nz_a, vecs[v].exp_nz_a);
      check($sformatf("vec%0d_nz_b", v), rdata_nz_b, vecs[v].exp_nz_b);
    end

    // Fill entries 1..31, make the outputs non-zero, then reset while both
    // ports request reads: outputs and contents must all be zero.
    for (int i = 1; i < 32; i++) step(1, 1, 5'(i), 32'hA5000000 | i, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 1, 1, 31);
    check("fill_a", rdata_a, 32'hA5000001);
    check("fill_b", rdata_b, 32'hA500001F);
    step(0, 0, 0, 0, 1, 1, 1, 31);
    check("rst_edge_a", rdata_a, 32'h0);
    check("rst_edge_b", rdata_b, 32'h0);
    step(1, 0, 0, 0, 1, 1, 1, 31);
    check("post_rst_a", rdata_a, 32'h0);
    check("post_rst_b", rdata_b, 32'h0);

    // Randomized traffic; narrow address ranges half the time so that
    // collisions and same-address reads occur often.
    for (int n = 0; n < 3000; n++) begin
      logic       r, w, ea, eb, narrow;
      logic [4:0] wa, ra, rb;
      rf_word_t   wd;
      narrow = 1'($urandom_range(0, 1));
      r  = ($urandom_range(0, 63) != 0);
      w  = 1'($urandom_range(0, 1));
      ea = 1'($urandom_range(0, 1));
      eb = 1'($urandom_range(0, 1));
      wa = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      ra = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      rb = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      wd = $urandom;
      step(r, w, wa, wd, ea, ra, eb, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
